fetch_unit: RTL and testbench

Instruction fetch stage directly upstream of the control unit and instruction register.
- On a fetch request it reads the instruction at pc from instruction memory over a variable-latency req/ack handshake.
- It holds the fetched word and presents it with a valid flag until the control unit consumes it (LoadIR).
- It reports misaligned-PC and memory-timeout faults, and discards in-flight fetches on flush (taken branch).

---
 rtl/fetch_unit.sv | 177 +++++++++++++++++
 tb/tb_fetch_unit.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues one imem read per fetch request over a req/ack
// handshake and holds the returned word until the control unit consumes it.
module fetch_unit #(
  parameter int unsigned TIMEOUT   = 16,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        fetch_req,
  input  logic [31:0] pc,
  input  logic        flush,
  input  logic        instr_consume,
  input  logic        fault_clear,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [6:0]  opcode,
  output logic        instr_valid,
  output logic        busy,
  output logic        fault,
  output logic [1:0]  fault_code
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  localparam logic [1:0] FC_NONE     = 2'b00;
  localparam logic [1:0] FC_MISALIGN = 2'b01;
  localparam logic [1:0] FC_TIMEOUT  = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_DRAIN,
    S_HOLD,
    S_FAULT
  } state_t;

  state_t           state_q, state_d;
  logic             req_q, req_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      instr_q, instr_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             fault_q, fault_d;
  logic [1:0]       code_q, code_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    addr_d  = addr_q;
    instr_d = instr_q;
    valid_d = valid_q;
    fault_d = fault_q;
    code_d  = code_q;
    cnt_d   = cnt_q;

    case (state_q)
      S_IDLE, S_HOLD: begin
        if (flush) begin
          // Taken branch invalidates the held word but keeps its value visible.
          if (state_q == S_HOLD) begin
            state_d = S_IDLE;
            valid_d = 1'b0;
          end
        end else if (fetch_req) begin
          valid_d = 1'b0;
          if (pc[1:0] != 2'b00) begin
            state_d = S_FAULT;
            fault_d = 1'b1;
            code_d  = FC_MISALIGN;
          end else begin
            state_d = S_WAIT;
            req_d   = 1'b1;
            addr_d  = pc;
            cnt_d   = '0;
          end
        end else if (instr_consume) begin
          valid_d = 1'b0;
        end
      end

      S_WAIT: begin
        if (imem_ack) begin
          req_d = 1'b0;
          if (flush) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_HOLD;
            instr_d = imem_rdata;
            valid_d = 1'b1;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_FAULT;
          req_d   = 1'b0;
          fault_d = 1'b1;
          code_d  = FC_TIMEOUT;
        end else begin
          cnt_d = sat_inc(cnt_q);
          // The request must complete even after a flush, so keep it up and drop the data later.
          if (flush) state_d = S_DRAIN;
        end
      end

      S_DRAIN: begin
        if (imem_ack) begin
          state_d = S_IDLE;
          req_d   = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_FAULT;
          req_d   = 1'b0;
          fault_d = 1'b1;
          code_d  = FC_TIMEOUT;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end

      S_FAULT: begin
        if (fault_clear) begin
          state_d = S_IDLE;
          fault_d = 1'b0;
          code_d  = FC_NONE;
        end
      end

      default: begin
        state_d = S_IDLE;
        req_d   = 1'b0;
      end
    endcase

    busy_d = (state_d == S_WAIT) || (state_d == S_DRAIN);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      req_q   <= 1'b0;
      addr_q  <= '0;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      fault_q <= 1'b0;
      code_q  <= FC_NONE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      fault_q <= fault_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign instr       = instr_q;
  assign opcode      = instr_q[6:0];
  assign instr_valid = valid_q;
  assign busy        = busy_q;
  assign fault       = fault_q;
  assign fault_code  = code_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios followed by randomized traffic, all
// checked against a transaction-level model of the fetch stage.
module tb_fetch_unit;

  localparam int unsigned TO  = 16;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        fetch_req = 1'b0;
  logic [31:0] pc = '0;
  logic        flush = 1'b0;
  logic        instr_consume = 1'b0;
  logic        fault_clear = 1'b0;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] instr;
  logic [6:0]  opcode;
  logic        instr_valid;
  logic        busy;
  logic        fault;
  logic [1:0]  fault_code;

  always #5 clock = ~clock;

  fetch_unit #(.TIMEOUT(TO), .NOP_INSTR(NOP)) dut (
    .clock(clock), .reset(reset), .fetch_req(fetch_req), .pc(pc), .flush(flush),
    .instr_consume(instr_consume), .fault_clear(fault_clear),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .instr(instr), .opcode(opcode),
    .instr_valid(instr_valid), .busy(busy), .fault(fault), .fault_code(fault_code)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Model: one outstanding request with an age, a drop flag for flushed
  // requests, the held word and the latched fault code.
  bit          m_out, m_drop, m_valid;
  int unsigned m_age;
  logic [31:0] m_addr, m_instr;
  logic [1:0]  m_code;

  task automatic model_reset();
    m_out = 0; m_drop = 0; m_valid = 0; m_age = 0;
    m_addr = '0; m_instr = NOP; m_code = 2'b00;
  endtask

  task automatic model_edge();
    if (m_code != 2'b00) begin
      if (fault_clear) m_code = 2'b00;
    end else if (m_out) begin
      if (imem_ack) begin
        m_out = 0;
        if (!m_drop && !flush) begin
          m_instr = imem_rdata;
          m_valid = 1;
        end
      end else if (m_age + 1 >= TO) begin
        m_out  = 0;
        m_code = 2'b10;
      end else begin
        m_age++;
        if (flush) m_drop = 1;
      end
    end else begin
      if (flush) m_valid = 0;
      else if (fetch_req) begin
        m_valid = 0;
        if (pc[1:0] != 2'b00) m_code = 2'b01;
        else begin
          m_out = 1; m_addr = pc; m_age = 0; m_drop = 0;
        end
      end else if (instr_consume) m_valid = 0;
    end
  endtask

  task automatic check_all(input string p);
    chk({p, "_req"},   32'(imem_req),    32'(m_out));
    chk({p, "_addr"},  imem_addr,        m_addr);
    chk({p, "_instr"}, instr,            m_instr);
    chk({p, "_opc"},   32'(opcode),      32'(m_instr[6:0]));
    chk({p, "_valid"}, 32'(instr_valid), 32'(m_valid));
    chk({p, "_busy"},  32'(busy),        32'(m_out));
    chk({p, "_fault"}, 32'(fault),       32'(m_code != 2'b00));
    chk({p, "_code"},  32'(fault_code),  32'(m_code));
  endtask

  task automatic step(input string p);
    model_edge();
    @(posedge clock);
    @(negedge clock);
    check_all(p);
  endtask

  task automatic quiet();
    fetch_req = 0; flush = 0; instr_consume = 0; fault_clear = 0; imem_ack = 0;
  endtask

  task automatic async_reset_pulse(input string p);
    #2 reset = 1'b0;
    #1;
    chk({p, "_rst_req"},   32'(imem_req), 32'd0);
    chk({p, "_rst_instr"}, instr,         NOP);
    chk({p, "_rst_busy"},  32'(busy),     32'd0);
    model_reset();
    @(negedge clock);
    reset = 1'b1;
  endtask

  int cnt;
  logic [31:0] saved;

  initial begin
    model_reset();
    quiet();
    repeat (2) @(negedge clock);
    check_all("reset");
    chk("reset_instr", instr, 32'h0000_0013);
    reset = 1'b1;

    // Zero-wait fetch and consume
    fetch_req = 1; pc = 32'h8; step("t1a");
    chk("t1_addr", imem_addr, 32'h8);
    chk("t1_valid_early", 32'(instr_valid), 32'd0);
    fetch_req = 0; imem_ack = 1; imem_rdata = 32'h0050_0093; step("t1b");
    chk("t1_instr", instr, 32'h0050_0093);
    chk("t1_opcode", 32'(opcode), 32'h13);
    chk("t1_valid", 32'(instr_valid), 32'd1);
    imem_ack = 0; instr_consume = 1; step("t1c");
    chk("t1_consumed", 32'(instr_valid), 32'd0);
    chk("t1_kept", instr, 32'h0050_0093);
    instr_consume = 0;

    // Delayed ack
    fetch_req = 1; pc = 32'h100; step("t2a");
    fetch_req = 0;
    for (int i = 0; i < 4; i++) begin
      step("t2w");
      chk("t2_req", 32'(imem_req), 32'd1);
      chk("t2_addr", imem_addr, 32'h100);
      chk("t2_busy", 32'(busy), 32'd1);
      chk("t2_novalid", 32'(instr_valid), 32'd0);
    end
    imem_ack = 1; imem_rdata = 32'h1234_5677; step("t2b");
    chk("t2_valid", 32'(instr_valid), 32'd1);
    chk("t2_instr", instr, 32'h1234_5677);
    imem_ack = 0;

    // Misaligned pc fault, clear, then a good fetch
    fetch_req = 1; pc = 32'h102; step("t3a");
    chk("t3_fault", 32'(fault), 32'd1);
    chk("t3_code", 32'(fault_code), 32'd1);
    chk("t3_noreq", 32'(imem_req), 32'd0);
    pc = 32'h104; step("t3b");
    chk("t3_ignored", 32'(imem_req), 32'd0);
    fetch_req = 0; fault_clear = 1; step("t3c");
    chk("t3_clear", 32'(fault_code), 32'd0);
    fault_clear = 0; fetch_req = 1; pc = 32'h104; step("t3d");
    chk("t3_addr", imem_addr, 32'h104);
    fetch_req = 0; imem_ack = 1; imem_rdata = 32'h0000_0093; step("t3e");
    chk("t3_valid", 32'(instr_valid), 32'd1);
    imem_ack = 0;

    // Timeout
    fetch_req = 1; pc = 32'h200; step("t4a");
    fetch_req = 0;
    cnt = 0;
    for (int i = 0; i < 40 && imem_req; i++) begin
      cnt++;
      step("t4w");
    end
    chk("t4_req_cycles", 32'(cnt), 32'(TO));
    chk("t4_code", 32'(fault_code), 32'd2);
    chk("t4_req_low", 32'(imem_req), 32'd0);
    saved = instr;
    imem_ack = 1; imem_rdata = 32'hCAFE_F00D; step("t4s");
    chk("t4_stray", instr, saved);
    imem_ack = 0; fault_clear = 1; step("t4c");
    fault_clear = 0;

    // Flush into drain, then flush in HOLD
    saved = instr;
    fetch_req = 1; pc = 32'h300; step("t5a");
    fetch_req = 0; step("t5b");
    flush = 1; step("t5c");
    flush = 0;
    chk("t5_drain_req", 32'(imem_req), 32'd1);
    chk("t5_drain_busy", 32'(busy), 32'd1);
    imem_ack = 1; imem_rdata = 32'hDEAD_BEEF; step("t5d");
    imem_ack = 0;
    chk("t5_instr", instr, saved);
    chk("t5_valid", 32'(instr_valid), 32'd0);
    chk("t5_idle", 32'(busy), 32'd0);
    fetch_req = 1; pc = 32'h310; step("t5e");
    fetch_req = 0; imem_ack = 1; imem_rdata = 32'h0000_0113; step("t5f");
    imem_ack = 0; flush = 1; step("t5g");
    flush = 0;
    chk("t5_hold_flush", 32'(instr_valid), 32'd0);
    chk("t5_hold_instr", instr, 32'h0000_0113);

    // Async reset mid-WAIT, then a late ack
    fetch_req = 1; pc = 32'h400; step("t6a");
    fetch_req = 0; step("t6b");
    async_reset_pulse("t6");
    imem_ack = 1; imem_rdata = 32'h1111_1111; step("t6c");
    imem_ack = 0;

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      int slow;
      slow = (c / 500) % 2;
      fetch_req     = ($urandom_range(0, 2) == 0);
      pc            = {$urandom_range(0, 32'hFFFF), 2'b00} |
                      (($urandom_range(0, 7) == 0) ? 32'($urandom_range(1, 3)) : 32'd0);
      flush         = ($urandom_range(0, 9) == 0);
      instr_consume = ($urandom_range(0, 3) == 0);
      fault_clear   = ($urandom_range(0, 5) == 0);
      imem_ack      = slow ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 1) == 0);
      imem_rdata    = $urandom;
      if ($urandom_range(0, 499) == 0) begin
        async_reset_pulse("rnd");
      end else begin
        step("rnd");
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
